// File: rtl/freq_div_prog_if.sv
// Control and status bundle of the programmable clock divider: divide-register
// access on one side, per-channel ticks/divided clocks and scan select on the other.
interface freq_div_prog_if #(
   parameter int NUM_CH = 3,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 27,
   parameter int SCAN_W = 2
);
   logic              en;
   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_val;
   logic [CNT_W-1:0]  div_rd;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] clk_out;
   logic [SCAN_W-1:0] clk_ctl;

   modport master (
      output en, div_wr, div_sel, div_val,
      input  div_rd, tick, clk_out, clk_ctl
   );

   modport slave (
      input  en, div_wr, div_sel, div_val,
      output div_rd, tick, clk_out, clk_ctl
   );
endinterface

// File: rtl/freq_div_prog.sv
// NUM_CH independently programmable divided clocks with tick strobes, plus a
// free-running prescaled scan select for the seven-segment display.
module freq_div_prog #(
   parameter int                NUM_CH      = 3,
   parameter int                SEL_W       = 2,
   parameter int                CNT_W       = 27,
   parameter logic [CNT_W-1:0]  DIV_DEFAULT = CNT_W'(24999),
   parameter int                SCAN_W      = 2,
   parameter int                SCAN_PRE_W  = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   freq_div_prog_if.slave       bus
);

   logic [CNT_W-1:0]      cnt_q [NUM_CH];
   logic [CNT_W-1:0]      cnt_d [NUM_CH];
   logic [CNT_W-1:0]      div_q [NUM_CH];
   logic [CNT_W-1:0]      div_d [NUM_CH];
   logic [NUM_CH-1:0]     tick_q, tick_d;
   logic [NUM_CH-1:0]     clk_out_q, clk_out_d;
   logic [SCAN_PRE_W-1:0] pre_q, pre_d;
   logic [SCAN_W-1:0]     ctl_q, ctl_d;
   logic [CNT_W-1:0]      div_rd;

   // A write to a channel overrides its terminal count: the counter restarts
   // and neither a tick nor a toggle is produced on that edge.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         // NOTE: every next-state value is defaulted first so no path through
         // the branches below leaves it unassigned and infers a latch.
         cnt_d[i]     = cnt_q[i];
         div_d[i]     = div_q[i];
         tick_d[i]    = 1'b0;
         clk_out_d[i] = clk_out_q[i];
         if (bus.div_wr && (bus.div_sel == SEL_W'(i))) begin
            div_d[i] = bus.div_val;
            cnt_d[i] = '0;
         end else if (bus.en) begin
            if (cnt_q[i] == div_q[i]) begin
               cnt_d[i]     = '0;
               tick_d[i]    = 1'b1;
               clk_out_d[i] = ~clk_out_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Scan select runs from the crystal regardless of en or register writes.
   always_comb begin
      pre_d = pre_q + SCAN_PRE_W'(1);
      ctl_d = ctl_q;
      if (pre_q == {SCAN_PRE_W{1'b1}}) begin
         ctl_d = ctl_q + SCAN_W'(1);
      end
   end

   // Unmapped selects read as zero.
   always_comb begin
      div_rd = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.div_sel == SEL_W'(i)) begin
            div_rd = div_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the divide registers are a handful of flops, not a RAM, so
         // they take a reset value like any other state.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= DIV_DEFAULT;
         end
         tick_q    <= '0;
         clk_out_q <= '0;
         pre_q     <= '0;
         ctl_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // present before this edge, independent of statement order.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
            div_q[i] <= div_d[i];
         end
         tick_q    <= tick_d;
         clk_out_q <= clk_out_d;
         pre_q     <= pre_d;
         ctl_q     <= ctl_d;
      end
   end

   assign bus.tick    = tick_q;
   assign bus.clk_out = clk_out_q;
   assign bus.clk_ctl = ctl_q;
   assign bus.div_rd  = div_rd;

endmodule

// File: tb/tb_freq_div_prog.sv
// Directed bench for freq_div_prog with small parameters (8-bit counters, divide
// default 4, 8-clock scan prescaler); expected values are hand-derived per edge.
module tb_freq_div_prog;

   localparam int NUM_CH     = 3;
   localparam int SEL_W      = 2;
   localparam int CNT_W      = 8;
   localparam int SCAN_W     = 2;
   localparam int SCAN_PRE_W = 3;
   localparam logic [CNT_W-1:0] DIV_DEF = 8'd4;

   typedef struct {
      logic              en;
      logic              wr;
      logic [SEL_W-1:0]  sel;
      logic [CNT_W-1:0]  val;
      logic [NUM_CH-1:0] tick;
      logic [NUM_CH-1:0] clk_out;
      logic [SCAN_W-1:0] ctl;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vq[$];

   freq_div_prog_if #(.NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W), .SCAN_W(SCAN_W)) bus ();

   freq_div_prog #(
      .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEF),
      .SCAN_W(SCAN_W), .SCAN_PRE_W(SCAN_PRE_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, input logic wr, input logic [SEL_W-1:0] sel,
                      input logic [CNT_W-1:0] val, input logic [NUM_CH-1:0] tick,
                      input logic [NUM_CH-1:0] clk_out, input logic [SCAN_W-1:0] ctl);
      vq.push_back('{en: en, wr: wr, sel: sel, val: val, tick: tick, clk_out: clk_out, ctl: ctl});
   endtask

   task automatic check_outs(input string tag, input logic [NUM_CH-1:0] tick,
                             input logic [NUM_CH-1:0] clk_out, input logic [SCAN_W-1:0] ctl);
      check({tag, " tick"},    32'(bus.tick),    32'(tick));
      check({tag, " clk_out"}, 32'(bus.clk_out), 32'(clk_out));
      check({tag, " clk_ctl"}, 32'(bus.clk_ctl), 32'(ctl));
   endtask

   task automatic check_rd(input string tag, input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] exp);
      bus.div_sel = sel;
      #1;
      check($sformatf("%s div_rd sel%0d", tag, sel), 32'(bus.div_rd), 32'(exp));
   endtask

   initial begin
      // Rows are edges 1..37 after reset release; each row's inputs are applied
      // before its edge and outputs checked at the following negedge.
      // Edges 1-12: all channels N=4 in phase.
      add(1,0,0,0, 3'b000,3'b000,0);  add(1,0,0,0, 3'b000,3'b000,0);
      add(1,0,0,0, 3'b000,3'b000,0);  add(1,0,0,0, 3'b000,3'b000,0);
      add(1,0,0,0, 3'b111,3'b111,0);  add(1,0,0,0, 3'b000,3'b111,0);
      add(1,0,0,0, 3'b000,3'b111,0);  add(1,0,0,0, 3'b000,3'b111,1);
      add(1,0,0,0, 3'b000,3'b111,1);  add(1,0,0,0, 3'b111,3'b000,1);
      add(1,0,0,0, 3'b000,3'b000,1);  add(1,0,0,0, 3'b000,3'b000,1);
      // Edge 13: ch1 <- N=0; ch1 ticks every clock from edge 14.
      add(1,1,1,0, 3'b000,3'b000,1);  add(1,0,0,0, 3'b010,3'b010,1);
      add(1,0,0,0, 3'b111,3'b101,1);  add(1,0,0,0, 3'b010,3'b111,2);
      add(1,0,0,0, 3'b010,3'b101,2);  add(1,0,0,0, 3'b010,3'b111,2);
      add(1,0,0,0, 3'b010,3'b101,2);
      // Edge 20: ch0 <- N=2 exactly at its terminal count; no tick, clk_out[0] holds.
      add(1,1,0,2, 3'b110,3'b011,2);  add(1,0,0,0, 3'b010,3'b001,2);
      add(1,0,0,0, 3'b010,3'b011,2);  add(1,0,0,0, 3'b011,3'b000,2);
      add(1,0,0,0, 3'b010,3'b010,3);  add(1,0,0,0, 3'b110,3'b100,3);
      add(1,0,0,0, 3'b011,3'b111,3);  add(1,0,0,0, 3'b010,3'b101,3);
      // Edges 28-34: en low with ch2 at cnt=2; scan keeps stepping (3 -> 0).
      for (int i = 28; i <= 34; i++) add(0,0,0,0, 3'b000,3'b101, (i < 32) ? 2'd3 : 2'd0);
      // Edges 35-37: resume; ch2 ticks on the third enabled edge.
      add(1,0,0,0, 3'b010,3'b111,0);  add(1,0,0,0, 3'b011,3'b100,0);
      add(1,0,0,0, 3'b110,3'b010,0);

      rst_n       = 1'b0;
      bus.en      = 1'b1;
      bus.div_wr  = 1'b0;
      bus.div_sel = '0;
      bus.div_val = '0;
      repeat (2) @(negedge clk);
      check_outs("reset", 3'b000, 3'b000, 0);
      check_rd("reset", 0, DIV_DEF);
      check_rd("reset", 2, DIV_DEF);
      bus.div_sel = '0;
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         bus.en      = vq[i].en;
         bus.div_wr  = vq[i].wr;
         bus.div_sel = vq[i].sel;
         bus.div_val = vq[i].val;
         @(negedge clk);
         check_outs($sformatf("edge%0d", i + 1), vq[i].tick, vq[i].clk_out, vq[i].ctl);
      end

      // Edge 38: write to unmapped select 3 must change nothing.
      bus.en      = 1'b1;
      bus.div_wr  = 1'b1;
      bus.div_sel = 2'd3;
      bus.div_val = 8'h55;
      #1;
      check("unmapped div_rd", 32'(bus.div_rd), 32'd0);
      @(negedge clk);
      bus.div_wr = 1'b0;
      check_outs("edge38", 3'b010, 3'b000, 0);
      check_rd("readback", 0, 8'd2);
      check_rd("readback", 1, 8'd0);
      check_rd("readback", 2, 8'd4);
      check_rd("readback", 3, 8'd0);
      bus.div_sel = '0;
      @(negedge clk);
      check_outs("edge39", 3'b011, 3'b011, 0);
      repeat (2) @(negedge clk);
      check("edge41 clk_ctl", 32'(bus.clk_ctl), 32'd1);

      // Asynchronous reset mid-count: outputs clear without waiting for an edge.
      #2 rst_n = 1'b0;
      #1;
      check_outs("async reset", 3'b000, 3'b000, 0);
      check_rd("async reset", 0, DIV_DEF);
      check_rd("async reset", 1, DIV_DEF);
      bus.div_sel = '0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check_outs($sformatf("post-reset edge%0d", k),
                    (k == 5) ? 3'b111 : 3'b000, (k == 5) ? 3'b111 : 3'b000, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
